// File: rtl/acc_drain_bank.sv
// Parallel lane accumulator bank. Each accepted beat loads or adds a vector of signed lane values.
// A drain request serialises the lane sums to an output buffer whose base address rotates between drains.
module acc_drain_bank #(
  parameter int ARR_SIZE = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int SAT_EN   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [ARR_SIZE*DATA_W-1:0]   in_data,
  input  logic                         acc_clear,
  output logic                         in_ready,
  input  logic                         drain_start,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH)-1:0]     out_addr,
  output logic                         busy,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
  localparam logic [LW-1:0]     LAST_LANE = LW'(ARR_SIZE - 1);
  localparam logic [DATA_W-1:0] MAX_POS   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG   = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t              state_q;
  logic [LW-1:0]       lane_q;
  logic [AW-1:0]       base_q;
  logic                overflow_q;
  logic [DATA_W-1:0]   acc_q    [ARR_SIZE];
  logic [DATA_W-1:0]   acc_d    [ARR_SIZE];
  logic [DATA_W-1:0]   lane_val [ARR_SIZE];
  logic [DATA_W-1:0]   wrap_sum [ARR_SIZE];
  logic [ARR_SIZE-1:0] lane_ovf;
  logic                beat_ovf;

  // Signed overflow: operands agree in sign but the wrapped result does not.
  always_comb begin
    beat_ovf = 1'b0;
    lane_ovf = '0;
    for (int i = 0; i < ARR_SIZE; i++) begin
      lane_val[i] = in_data[i*DATA_W +: DATA_W];
      wrap_sum[i] = acc_q[i] + lane_val[i];
      lane_ovf[i] = (acc_q[i][DATA_W-1] == lane_val[i][DATA_W-1]) &&
                    (wrap_sum[i][DATA_W-1] != acc_q[i][DATA_W-1]);
      if (acc_clear)
        acc_d[i] = lane_val[i];
      else if (lane_ovf[i] && (SAT_EN != 0))
        acc_d[i] = acc_q[i][DATA_W-1] ? MIN_NEG : MAX_POS;
      else
        acc_d[i] = wrap_sum[i];
    end
    if (!acc_clear && (lane_ovf != '0))
      beat_ovf = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      base_q     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < ARR_SIZE; i++) acc_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < ARR_SIZE; i++) acc_q[i] <= acc_d[i];
          end
          // A beat accepted alongside drain_start can still flag overflow for this drain.
          if (drain_start) begin
            state_q    <= DRAIN;
            lane_q     <= '0;
            overflow_q <= in_valid && beat_ovf;
          end else if (in_valid && beat_ovf) begin
            overflow_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (lane_q == LAST_LANE) begin
              state_q <= IDLE;
              lane_q  <= '0;
              base_q  <= base_q + AW'(ARR_SIZE);
              for (int i = 0; i < ARR_SIZE; i++) acc_q[i] <= '0;
            end else begin
              lane_q <= lane_q + LW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == DRAIN);
  assign out_valid = (state_q == DRAIN);
  assign out_data  = (state_q == DRAIN) ? acc_q[lane_q] : '0;
  assign out_addr  = base_q + AW'(lane_q);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_acc_drain_bank.sv
// Directed bench for acc_drain_bank: a wrapping and a saturating instance share all stimulus.
`timescale 1ns/1ps
module tb_acc_drain_bank;
  typedef logic [31:0] vec_t [4];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic        acc_clear = 1'b0;
  logic        drain_start = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_w, out_valid_w, busy_w, overflow_w;
  logic [31:0] out_data_w;
  logic [3:0]  out_addr_w;
  logic        in_ready_s, out_valid_s, busy_s, overflow_s;
  logic [31:0] out_data_s;
  logic [3:0]  out_addr_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  acc_drain_bank #(.ARR_SIZE(4), .DATA_W(32), .DEPTH(16), .SAT_EN(0)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .acc_clear(acc_clear),
    .in_ready(in_ready_w), .drain_start(drain_start), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_data(out_data_w), .out_addr(out_addr_w), .busy(busy_w), .overflow(overflow_w));

  acc_drain_bank #(.ARR_SIZE(4), .DATA_W(32), .DEPTH(16), .SAT_EN(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .acc_clear(acc_clear),
    .in_ready(in_ready_s), .drain_start(drain_start), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_addr(out_addr_s), .busy(busy_s), .overflow(overflow_s));

  task automatic pack(input vec_t d);
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = d[i];
  endtask

  task automatic beat(input vec_t d, input logic clr);
    @(negedge clk);
    pack(d);
    in_valid = 1'b1;
    acc_clear = clr;
    @(negedge clk);
    in_valid = 1'b0;
    acc_clear = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Full drain with out_ready held high; optionally a beat accepted in the drain_start cycle.
  task automatic do_drain(input string tag, input vec_t ew, input vec_t es, input logic [3:0] base,
                          input logic with_beat, input vec_t bd);
    logic [3:0] ea;
    @(negedge clk);
    drain_start = 1'b1;
    out_ready = 1'b1;
    if (with_beat) begin
      pack(bd);
      in_valid = 1'b1;
    end
    @(negedge clk);
    drain_start = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ea = base + 4'(k);
      checks++;
      if (out_valid_w !== 1'b1 || out_data_w !== ew[k] || out_addr_w !== ea) begin
        failures++;
        $display("FAIL %s_wrap lane%0d: got valid=%b data=%h addr=%0d, expected valid=1 data=%h addr=%0d",
                 tag, k, out_valid_w, out_data_w, out_addr_w, ew[k], ea);
      end
      checks++;
      if (out_valid_s !== 1'b1 || out_data_s !== es[k] || out_addr_s !== ea) begin
        failures++;
        $display("FAIL %s_sat lane%0d: got valid=%b data=%h addr=%0d, expected valid=1 data=%h addr=%0d",
                 tag, k, out_valid_s, out_data_s, out_addr_s, es[k], ea);
      end
      @(negedge clk);
    end
    checks++;
    if (busy_w !== 1'b0 || in_ready_w !== 1'b1 || out_valid_w !== 1'b0) begin
      failures++;
      $display("FAIL %s_end: got busy=%b in_ready=%b out_valid=%b, expected 0 1 0", tag, busy_w, in_ready_w, out_valid_w);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid_w !== 1'b0 || busy_w !== 1'b0 || overflow_w !== 1'b0 || out_data_w !== 32'h0 || out_addr_w !== 4'h0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b busy=%b ovf=%b data=%h addr=%0d, expected all zero",
               out_valid_w, busy_w, overflow_w, out_data_w, out_addr_w);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready_w !== 1'b1 || in_ready_s !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b/%b, expected 1/1", in_ready_w, in_ready_s);
    end
  endtask

  task automatic test_basic();
    beat('{32'd1, 32'd2, 32'd3, 32'd4}, 1'b1);
    beat('{32'd10, 32'd20, 32'd30, 32'd40}, 1'b0);
    checks++;
    if (overflow_w !== 1'b0) begin
      failures++;
      $display("FAIL basic_no_ovf: got overflow=%b, expected 0", overflow_w);
    end
    do_drain("basic", '{32'd11, 32'd22, 32'd33, 32'd44}, '{32'd11, 32'd22, 32'd33, 32'd44}, 4'd0, 1'b0, '{0, 0, 0, 0});
  endtask

  task automatic test_backpressure();
    int busy_cycles = 0;
    beat('{32'd11, 32'd22, 32'd33, 32'd44}, 1'b1);
    @(negedge clk);
    drain_start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    if (busy_w === 1'b1) busy_cycles++;
    checks++;
    if (out_data_w !== 32'd11 || out_addr_w !== 4'd4) begin
      failures++;
      $display("FAIL bp_lane0: got data=%0d addr=%0d, expected 11 4", out_data_w, out_addr_w);
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    pack('{32'd100, 32'd100, 32'd100, 32'd100});
    drain_start = 1'b1;
    for (int s = 0; s < 3; s++) begin
      if (busy_w === 1'b1) busy_cycles++;
      checks++;
      if (out_valid_w !== 1'b1 || out_data_w !== 32'd22 || out_addr_w !== 4'd5 || in_ready_w !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall%0d: got valid=%b data=%0d addr=%0d in_ready=%b, expected 1 22 5 0",
                 s, out_valid_w, out_data_w, out_addr_w, in_ready_w);
      end
      @(negedge clk);
    end
    drain_start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (busy_w === 1'b1) busy_cycles++;
    checks++;
    if (out_data_w !== 32'd22 || out_addr_w !== 4'd5) begin
      failures++;
      $display("FAIL bp_release: got data=%0d addr=%0d, expected 22 5", out_data_w, out_addr_w);
    end
    @(negedge clk);
    if (busy_w === 1'b1) busy_cycles++;
    checks++;
    if (out_data_w !== 32'd33 || out_addr_w !== 4'd6) begin
      failures++;
      $display("FAIL bp_lane2: got data=%0d addr=%0d, expected 33 6", out_data_w, out_addr_w);
    end
    @(negedge clk);
    if (busy_w === 1'b1) busy_cycles++;
    checks++;
    if (out_data_w !== 32'd44 || out_addr_w !== 4'd7) begin
      failures++;
      $display("FAIL bp_lane3: got data=%0d addr=%0d, expected 44 7", out_data_w, out_addr_w);
    end
    @(negedge clk);
    if (busy_w === 1'b1) busy_cycles++;
    checks++;
    if (busy_cycles !== 7 || in_ready_w !== 1'b1) begin
      failures++;
      $display("FAIL bp_cycles: got busy_cycles=%0d in_ready=%b, expected 7 1", busy_cycles, in_ready_w);
    end
    // Beats offered during the drain must not have been absorbed.
    do_drain("bp_after", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 4'd8, 1'b0, '{0, 0, 0, 0});
  endtask

  task automatic test_wrap();
    pulse_reset();
    do_drain("wrap0", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 4'd0,  1'b0, '{0, 0, 0, 0});
    do_drain("wrap1", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 4'd4,  1'b0, '{0, 0, 0, 0});
    do_drain("wrap2", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 4'd8,  1'b0, '{0, 0, 0, 0});
    do_drain("wrap3", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 4'd12, 1'b0, '{0, 0, 0, 0});
    do_drain("wrap4", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 4'd0,  1'b0, '{0, 0, 0, 0});
  endtask

  task automatic test_saturation();
    beat('{32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0}, 1'b1);
    checks++;
    if (overflow_w !== 1'b0 || overflow_s !== 1'b0) begin
      failures++;
      $display("FAIL sat_load_no_ovf: got %b/%b, expected 0/0", overflow_w, overflow_s);
    end
    beat('{32'h0000_0001, 32'd0, 32'd0, 32'd0}, 1'b0);
    checks++;
    if (overflow_w !== 1'b1 || overflow_s !== 1'b1) begin
      failures++;
      $display("FAIL sat_pos_ovf: got %b/%b, expected 1/1", overflow_w, overflow_s);
    end
    do_drain("sat_pos", '{32'h8000_0000, 0, 0, 0}, '{32'h7FFF_FFFF, 0, 0, 0}, 4'd4, 1'b0, '{0, 0, 0, 0});
    checks++;
    if (overflow_w !== 1'b0 || overflow_s !== 1'b0) begin
      failures++;
      $display("FAIL sat_ovf_cleared: got %b/%b, expected 0/0", overflow_w, overflow_s);
    end
    beat('{32'h8000_0000, 32'hFFFF_FFFB, 32'd0, 32'd0}, 1'b1);
    beat('{32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0}, 1'b0);
    checks++;
    if (overflow_w !== 1'b1 || overflow_s !== 1'b1) begin
      failures++;
      $display("FAIL sat_neg_ovf: got %b/%b, expected 1/1", overflow_w, overflow_s);
    end
    do_drain("sat_neg", '{32'h7FFF_FFFF, 32'hFFFF_FFFE, 0, 0}, '{32'h8000_0000, 32'hFFFF_FFFE, 0, 0},
             4'd8, 1'b0, '{0, 0, 0, 0});
  endtask

  task automatic test_coincident();
    do_drain("coinc", '{5, 5, 5, 5}, '{5, 5, 5, 5}, 4'd12, 1'b1, '{5, 5, 5, 5});
  endtask

  task automatic test_reset_mid_drain();
    beat('{32'd1, 32'd1, 32'd1, 32'd1}, 1'b1);
    @(negedge clk);
    drain_start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (out_valid_w !== 1'b1 || out_addr_w !== 4'd2) begin
      failures++;
      $display("FAIL mid_pre_reset: got valid=%b addr=%0d, expected 1 2", out_valid_w, out_addr_w);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid_w !== 1'b0 || busy_w !== 1'b0 || out_data_w !== 32'h0 || out_addr_w !== 4'h0) begin
      failures++;
      $display("FAIL mid_async_reset: got valid=%b busy=%b data=%h addr=%0d, expected 0 0 0 0",
               out_valid_w, busy_w, out_data_w, out_addr_w);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid_w !== 1'b0 || in_ready_w !== 1'b1) begin
      failures++;
      $display("FAIL mid_post_reset: got valid=%b in_ready=%b, expected 0 1", out_valid_w, in_ready_w);
    end
    beat('{32'd7, 32'd7, 32'd7, 32'd7}, 1'b0);
    do_drain("mid_next", '{7, 7, 7, 7}, '{7, 7, 7, 7}, 4'd0, 1'b0, '{0, 0, 0, 0});
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_saturation();
    test_coincident();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
